fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage for the single-cycle RV32 core. It holds the PC, requests instructions from instruction memory over a ready-based handshake, and latches the returned word. It presents `op`, `funct3` and `funct7` to the controller. On each retire it consumes the controller's `PCSrc` together with the datapath's `PCTarget` to select the next PC. It also halts on illegal opcodes and misaligned redirect targets.

## Interface
- `RESET_PC`, default 32'h00000000: PC loaded on reset. Must be a multiple of 4.
- `NOP_INSTR`, default 32'h00000013: value of `Instr` while no valid instruction is held (addi x0,x0,0).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `PCSrc` input 1: from the controller. 1 = take `PCTarget`, 0 = take PC+4. Sampled only on retire.
- `PCTarget` input 32: branch/jump target from the datapath.
- `InstrAck` input 1: the downstream stage has finished the held instruction this cycle (retire).
- `IMemReady` input 1: instruction memory has data on `IMemRdata` this cycle.
- `IMemRdata` input 32: instruction word.
- `IMemReq` output 1: fetch request.
- `IMemAddr` output 32: fetch address. Always equals `PC`.
- `InstrValid` output 1: `Instr` and the decode fields are valid.
- `Instr` output 32: latched instruction.
- `op` output 7: `Instr[6:0]`.
- `funct3` output 3: `Instr[14:12]`.
- `funct7` output 1: `Instr[30]`.
- `PC` output 32: address of the held or requested instruction.
- `PCPlus4` output 32: `PC + 4`, mod 2^32.
- `IllegalInstr` output 1: sticky; an unsupported opcode was fetched.
- `Misaligned` output 1: sticky; a redirect target had `[1:0] != 0`.
- `Halted` output 1: `IllegalInstr | Misaligned`.

## Operation
- **Registered state:** `state` ∈ {BOOT, REQ, HOLD, HALT}, plus `PC`, `Instr` and the two error flags.
- **Outputs derived from state:** `IMemReq = (state==REQ)` and `InstrValid = (state==HOLD)`. The decode fields slice `Instr` combinationally.
- **BOOT:** entered on reset. The next edge always moves to REQ.
- **REQ:** `IMemReq=1`, `IMemAddr=PC`. At an edge with `IMemReady=1`:
  - Supported opcode: `Instr <= IMemRdata`, go to HOLD.
  - Otherwise: `IllegalInstr <= 1`, go to HALT. `Instr` stays `NOP_INSTR`.
  - If `IMemReady=0`, stay in REQ.
- **Supported opcodes:** 0000011 (lw), 0010011 (I-type ALU), 0100011 (sw), 0110011 (R-type), 1100011 (beq), 1101111 (jal), 0110111 (lui).
- **HOLD:** the instruction is held stable until an edge with `InstrAck=1`. At that edge:
  - `PCSrc=0`: `PC <= PCPlus4`, `Instr <= NOP_INSTR`, go to REQ.
  - `PCSrc=1` and `PCTarget[1:0]==0`: `PC <= PCTarget`, `Instr <= NOP_INSTR`, go to REQ.
  - `PCSrc=1` and `PCTarget[1:0]!=0`: `Misaligned <= 1`, go to HALT. `PC` and `Instr` are unchanged.
- **HALT:** absorbing; no requests. Leave only via `rst_n`. `InstrAck`, `PCSrc` and `IMemReady` are ignored.
- **Ignored inputs:** `InstrAck` outside HOLD, `IMemReady` outside REQ.
- **Arithmetic:** PC+4 wraps, so 32'hFFFFFFFC → 32'h00000000 with no flag. `PCTarget` is used as given, with no masking.

## Timing
- **Reset values (immediate on `rst_n` low, asynchronous):**
  - `state=BOOT`, `PC=RESET_PC`, `Instr=NOP_INSTR`.
  - `IMemReq=0`, `InstrValid=0`, `IllegalInstr=0`, `Misaligned=0`, `Halted=0`.
- **Reset mid-operation:** asserting reset during REQ or HOLD aborts it. A memory response arriving in the same cycle is discarded. The first request after reset is to `RESET_PC`.
- **After reset release:** edge 1 → REQ. `IMemReq` rises in the cycle after the first edge.
- **Fetch latency:** `IMemReady` high in the first REQ cycle gives `InstrValid=1` one cycle after `IMemReq` rose. Each wait cycle adds one cycle.
- **Throughput:** at most one instruction per 2 cycles (REQ, HOLD). With zero-wait memory and an immediate ack, the request-to-request spacing is 2 cycles.
- **Retire:** `PC` updates at the ack edge, and `IMemReq` asserts in the next cycle with the new `IMemAddr`.
- **Outputs are glitch-free per state:** `PC`, `Instr`, `op`, `funct3` and `funct7` change only on clock edges or reset.

## Test plan
- **Boot fetch:** `rst_n` low then high, memory ready every cycle, word 32'h00500093 → `IMemAddr=0` on the first request, then `InstrValid=1`, `op=0010011`, `funct3=000`.
- **Wait states and sequential PC:** hold `IMemReady=0` for 3 REQ cycles → `IMemReq` stays 1 with `IMemAddr` stable; valid follows ready. Ack with `PCSrc=0` → next `IMemAddr=4`.
- **Branch redirect:** at PC=8, ack with `PCSrc=1`, `PCTarget=32'h40` → next `IMemAddr=32'h40`, `PCPlus4=32'h44`.
- **Misaligned redirect:** ack with `PCSrc=1`, `PCTarget=32'h42` → `Misaligned=1`, `Halted=1`, no further `IMemReq`, `PC` unchanged.
- **Illegal opcode:** memory returns 32'h00000073 (system) → `IllegalInstr=1`, `InstrValid` never rises, `Instr=NOP_INSTR`. Further `InstrAck`/`IMemReady` pulses are ignored.
- **Reset mid-fetch and wrap:**
  - Assert `rst_n` low during REQ with `IMemReady=1` → `Instr=NOP_INSTR`, state restarts from `RESET_PC`.
  - With `RESET_PC=32'hFFFFFFFC`, ack with `PCSrc=0` → next `IMemAddr=0`.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction fetch stage: PC, handshaked imem request, instruction latch
// Halts stickily on unsupported opcodes and on misaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  input  logic        InstrAck,
  input  logic        IMemReady,
  input  logic [31:0] IMemRdata,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        IllegalInstr,
  output logic        Misaligned,
  output logic        Halted
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic        illegal_q, illegal_nxt;
  logic        misaligned_q, misaligned_nxt;

  function automatic logic opcode_supported(input logic [6:0] opc);
    case (opc)
      7'b0000011, 7'b0010011, 7'b0100011, 7'b0110011,
      7'b1100011, 7'b1101111, 7'b0110111: opcode_supported = 1'b1;
      default:                            opcode_supported = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc_q         <= pc_nxt;
      instr_q      <= instr_nxt;
      illegal_q    <= illegal_nxt;
      misaligned_q <= misaligned_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc_q;
    instr_nxt      = instr_q;
    illegal_nxt    = illegal_q;
    misaligned_nxt = misaligned_q;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        if (IMemReady) begin
          if (opcode_supported(IMemRdata[6:0])) begin
            instr_nxt = IMemRdata;
            state_nxt = HOLD;
          end else begin
            illegal_nxt = 1'b1;
            state_nxt   = HALT;
          end
        end
      end
      HOLD: begin
        if (InstrAck) begin
          if (!PCSrc) begin
            pc_nxt    = pc_q + 32'd4;
            instr_nxt = NOP_INSTR;
            state_nxt = REQ;
          end else if (PCTarget[1:0] == 2'b00) begin
            pc_nxt    = PCTarget;
            instr_nxt = NOP_INSTR;
            state_nxt = REQ;
          end else begin
            // PC and Instr stay frozen so the faulting retire can be inspected
            misaligned_nxt = 1'b1;
            state_nxt      = HALT;
          end
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  assign IMemReq      = (state == REQ);
  assign InstrValid   = (state == HOLD);
  assign PC           = pc_q;
  assign IMemAddr     = pc_q;
  assign PCPlus4      = pc_q + 32'd4;
  assign Instr        = instr_q;
  assign op           = instr_q[6:0];
  assign funct3       = instr_q[14:12];
  assign funct7       = instr_q[30];
  assign IllegalInstr = illegal_q;
  assign Misaligned   = misaligned_q;
  assign Halted       = illegal_q | misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - per-cycle vector table plus a PC wrap sequence for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic [31:0] rdata;
    logic        ack;
    logic        pcsrc;
    logic [31:0] target;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic        e_ill;
    logic        e_mis;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcsrc = 1'b0, ack = 1'b0, ready = 1'b0;
  logic [31:0] target = '0, rdata = '0;
  logic        req, valid, funct7, ill, mis, halted;
  logic [31:0] addr, instr, pc, pc4;
  logic [6:0]  op;
  logic [2:0]  funct3;

  logic        w_rst_n = 1'b0, w_pcsrc = 1'b0, w_ack = 1'b0, w_ready = 1'b0;
  logic [31:0] w_target = '0, w_rdata = '0;
  logic        w_req, w_valid, w_funct7, w_ill, w_mis, w_halted;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic [6:0]  w_op;
  logic [2:0]  w_funct3;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(pcsrc), .PCTarget(target), .InstrAck(ack),
    .IMemReady(ready), .IMemRdata(rdata), .IMemReq(req), .IMemAddr(addr),
    .InstrValid(valid), .Instr(instr), .op(op), .funct3(funct3), .funct7(funct7),
    .PC(pc), .PCPlus4(pc4), .IllegalInstr(ill), .Misaligned(mis), .Halted(halted)
  );

  fetch_unit #(.RESET_PC(32'hFFFFFFFC)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .PCSrc(w_pcsrc), .PCTarget(w_target), .InstrAck(w_ack),
    .IMemReady(w_ready), .IMemRdata(w_rdata), .IMemReq(w_req), .IMemAddr(w_addr),
    .InstrValid(w_valid), .Instr(w_instr), .op(w_op), .funct3(w_funct3), .funct7(w_funct7),
    .PC(w_pc), .PCPlus4(w_pc4), .IllegalInstr(w_ill), .Misaligned(w_mis), .Halted(w_halted)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic [31:0] rd,
                     input logic a, input logic s, input logic [31:0] t,
                     input logic er, input logic ev, input logic [31:0] ea,
                     input logic [31:0] ei, input logic eil, input logic emi);
    vec_t v;
    v.rst_n = r; v.ready = rdy; v.rdata = rd; v.ack = a; v.pcsrc = s; v.target = t;
    v.e_req = er; v.e_valid = ev; v.e_addr = ea; v.e_instr = ei; v.e_ill = eil; v.e_mis = emi;
    vq.push_back(v);
  endtask

  initial begin
    // inputs for the coming edge, then the outputs expected before that edge
    //  rst rdy rdata          ack src target         req val addr           instr          ill mis
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 0 reset
    add(1, 1, 32'h00500093,  0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 1 boot
    add(1, 1, 32'h00500093,  0, 0, 32'h0,         1, 0, 32'h00000000, NOP,          0, 0); // 2 first req
    add(1, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h00000000, 32'h00500093, 0, 0); // 3 hold
    add(1, 0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h00000000, 32'h00500093, 0, 0); // 4 ack seq
    add(1, 0, 32'h0,         1, 0, 32'h0,         1, 0, 32'h00000004, NOP,          0, 0); // 5 wait
    add(1, 0, 32'h0,         1, 1, 32'h80,        1, 0, 32'h00000004, NOP,          0, 0); // 6 wait
    add(1, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h00000004, NOP,          0, 0); // 7 wait
    add(1, 1, 32'h00208463,  0, 0, 32'h0,         1, 0, 32'h00000004, NOP,          0, 0); // 8 beq
    add(1, 0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h00000004, 32'h00208463, 0, 0); // 9
    add(1, 1, 32'h0000006F,  0, 0, 32'h0,         1, 0, 32'h00000008, NOP,          0, 0); // 10 jal
    add(1, 0, 32'h0,         1, 1, 32'h00000040,  0, 1, 32'h00000008, 32'h0000006F, 0, 0); // 11 redirect
    add(1, 1, 32'h00002083,  0, 0, 32'h0,         1, 0, 32'h00000040, NOP,          0, 0); // 12 lw
    add(1, 0, 32'h0,         1, 1, 32'h00000042,  0, 1, 32'h00000040, 32'h00002083, 0, 0); // 13 misaligned
    add(1, 1, 32'h00500093,  1, 0, 32'h0,         0, 0, 32'h00000040, 32'h00002083, 0, 1); // 14 halted
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 15 reset
    add(1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 16 boot
    add(1, 1, 32'h00000073,  0, 0, 32'h0,         1, 0, 32'h00000000, NOP,          0, 0); // 17 system
    add(1, 1, 32'h00500093,  1, 0, 32'h0,         0, 0, 32'h00000000, NOP,          1, 0); // 18 ignored
    add(1, 1, 32'h00500093,  1, 1, 32'h0,         0, 0, 32'h00000000, NOP,          1, 0); // 19 ignored
    add(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 20 reset
    add(1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 21 boot
    add(1, 0, 32'h0,         0, 0, 32'h0,         1, 0, 32'h00000000, NOP,          0, 0); // 22 req
    add(0, 1, 32'h00500093,  0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 23 reset mid-fetch
    add(1, 1, 32'h00000033,  0, 0, 32'h0,         0, 0, 32'h00000000, NOP,          0, 0); // 24 boot
    add(1, 1, 32'h00000033,  0, 0, 32'h0,         1, 0, 32'h00000000, NOP,          0, 0); // 25 R-type
    add(1, 0, 32'h0,         1, 0, 32'h0,         0, 1, 32'h00000000, 32'h00000033, 0, 0); // 26
    add(1, 1, 32'h123450B7,  0, 0, 32'h0,         1, 0, 32'h00000004, NOP,          0, 0); // 27 lui
    add(1, 0, 32'h0,         0, 0, 32'h0,         0, 1, 32'h00000004, 32'h123450B7, 0, 0); // 28

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; ready = vq[i].ready; rdata = vq[i].rdata;
      ack = vq[i].ack; pcsrc = vq[i].pcsrc; target = vq[i].target;
      #1;
      chk("req",     i, {31'b0, req},     {31'b0, vq[i].e_req});
      chk("valid",   i, {31'b0, valid},   {31'b0, vq[i].e_valid});
      chk("addr",    i, addr,             vq[i].e_addr);
      chk("pc",      i, pc,               vq[i].e_addr);
      chk("pcplus4", i, pc4,              vq[i].e_addr + 32'd4);
      chk("instr",   i, instr,            vq[i].e_instr);
      chk("op",      i, {25'b0, op},      {25'b0, vq[i].e_instr[6:0]});
      chk("funct3",  i, {29'b0, funct3},  {29'b0, vq[i].e_instr[14:12]});
      chk("funct7",  i, {31'b0, funct7},  {31'b0, vq[i].e_instr[30]});
      chk("illegal", i, {31'b0, ill},     {31'b0, vq[i].e_ill});
      chk("misalign",i, {31'b0, mis},     {31'b0, vq[i].e_mis});
      chk("halted",  i, {31'b0, halted},  {31'b0, vq[i].e_ill | vq[i].e_mis});
      if (i == 3) begin
        chk("boot_op", i, {25'b0, op}, 32'h13);
        chk("boot_f3", i, {29'b0, funct3}, 32'h0);
      end
      if (i == 13) chk("redir_pc4", i, pc4, 32'h44);
    end

    // PC wrap from the top of the address space
    @(negedge clk); w_rst_n = 1'b0; #1;
    chk("wrap_rst_addr", 100, w_addr, 32'hFFFFFFFC);
    chk("wrap_rst_pc4",  100, w_pc4,  32'h00000000);
    @(negedge clk); w_rst_n = 1'b1; w_ready = 1'b1; w_rdata = 32'h00000013;
    @(negedge clk); #1;
    chk("wrap_req",  101, {31'b0, w_req}, 32'h1);
    chk("wrap_addr", 101, w_addr, 32'hFFFFFFFC);
    @(negedge clk); #1;
    chk("wrap_valid", 102, {31'b0, w_valid}, 32'h1);
    w_ready = 1'b0; w_ack = 1'b1; w_pcsrc = 1'b0;
    @(negedge clk); w_ack = 1'b0; #1;
    for (int k = 0; k < 8 && !w_req; k++) @(negedge clk);
    chk("wrap_next_req",  103, {31'b0, w_req}, 32'h1);
    chk("wrap_next_addr", 103, w_addr, 32'h00000000);
    chk("wrap_halted",    103, {31'b0, w_halted}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
